// File: rtl/camera_pkg.sv
// Shared types and helpers for the camera frame-buffer write path.
// Pixel-width decode and the slot geometry derived from it live here.
package camera_pkg;

    localparam int WORD_BITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH,
        DONE
    } writer_state_t;

    // 16 does not fit the 4-bit width field, so it arrives as its low nibble, 4'd0.
    typedef enum logic [3:0] {
        PW_16 = 4'd0,
        PW_4  = 4'd4,
        PW_8  = 4'd8
    } pixel_width_t;

    function automatic pixel_width_t decode_width(input logic [3:0] code);
        case (code)
            4'd0:    return PW_16;
            4'd4:    return PW_4;
            default: return PW_8;
        endcase
    endfunction

    function automatic logic [5:0] width_bits(input pixel_width_t w);
        case (w)
            PW_16:   return 6'd16;
            PW_4:    return 6'd4;
            default: return 6'd8;
        endcase
    endfunction

    function automatic logic [3:0] width_slots(input pixel_width_t w);
        case (w)
            PW_16:   return 4'd2;
            PW_4:    return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/camera_buffer_writer_pixel_packer.sv
// Accumulates pixels MSB-slot first into a 32-bit word and reports a word
// when it fills, or when a flush finds a partially filled word.
module pixel_packer
    import camera_pkg::*;
(
    input  logic                 clock_spi_in,
    input  logic                 reset_sync_n,
    input  logic                 clear_in,
    input  logic                 push_in,
    input  logic                 flush_in,
    input  pixel_width_t         width_in,
    input  logic [9:0]           rgb10_in,
    input  logic [7:0]           rgb8_in,
    input  logic [3:0]           gray4_in,
    output logic                 emit_out,
    output logic [WORD_BITS-1:0] word_out
);

    logic [WORD_BITS-1:0] acc_q, acc_d;
    logic [3:0]           slot_cnt_q, slot_cnt_d;

    logic [WORD_BITS-1:0] acc_base, acc_shift, slot_val;
    logic [3:0]           cnt_base, cnt_inc, slots;
    logic [5:0]           bits, pad_bits;

    always_comb begin
        bits     = width_bits(width_in);
        slots    = width_slots(width_in);
        acc_base = clear_in ? '0 : acc_q;
        cnt_base = clear_in ? '0 : slot_cnt_q;

        case (width_in)
            PW_16:   slot_val = {16'b0, rgb10_in, 6'b0};
            PW_4:    slot_val = {28'b0, gray4_in};
            default: slot_val = {24'b0, rgb8_in};
        endcase

        acc_shift = (acc_base << bits) | slot_val;
        cnt_inc   = cnt_base + 4'd1;
        // Left-align a partial word so the unfilled LS slots read as zero.
        pad_bits  = 6'(WORD_BITS) - bits * {2'b0, cnt_base};

        acc_d      = acc_base;
        slot_cnt_d = cnt_base;
        emit_out   = 1'b0;
        word_out   = '0;

        if (push_in) begin
            if (cnt_inc == slots) begin
                emit_out   = 1'b1;
                word_out   = acc_shift;
                acc_d      = '0;
                slot_cnt_d = '0;
            end else begin
                acc_d      = acc_shift;
                slot_cnt_d = cnt_inc;
            end
        end else if (flush_in && (cnt_base != 4'd0)) begin
            emit_out   = 1'b1;
            word_out   = acc_base << pad_bits;
            acc_d      = '0;
            slot_cnt_d = '0;
        end
    end

    always_ff @(posedge clock_spi_in or negedge reset_sync_n) begin
        if (!reset_sync_n) begin
            acc_q      <= '0;
            slot_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            slot_cnt_q <= slot_cnt_d;
        end
    end

endmodule

// File: rtl/camera_buffer_writer.sv
// Write end of the camera frame buffer: frame FSM, word addressing, fill
// count with saturation, overflow flag and the registered RAM write port.
module camera_buffer_writer
    import camera_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 14
) (
    input  logic                     clock_spi_in,
    input  logic                     reset_sync_n,
    input  logic [9:0]               rgb10_in,
    input  logic [7:0]               rgb8_in,
    input  logic [3:0]               gray4_in,
    input  logic [3:0]               pixel_width_in,
    input  logic                     write_enable_in,
    input  logic                     frame_valid_in,
    output logic                     write_enable_out,
    output logic [WORD_BITS-1:0]     pixel_data_out,
    output logic [ADDRESS_WIDTH-1:0] address_out,
    output logic [ADDRESS_WIDTH:0]   words_written_out,
    output logic                     frame_done_out,
    output logic                     overflow_out
);

    // Count tops out at the buffer depth; the MSB alone marks a full buffer.
    function automatic logic [ADDRESS_WIDTH:0] sat_inc(input logic [ADDRESS_WIDTH:0] c);
        return c[ADDRESS_WIDTH] ? c : c + {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    endfunction

    writer_state_t              state_q, state_d;
    pixel_width_t               width_q, width_d;
    logic                       write_enable_q, write_enable_d;
    logic [WORD_BITS-1:0]       pixel_data_q, pixel_data_d;
    logic [ADDRESS_WIDTH-1:0]   address_q, address_d;
    logic [ADDRESS_WIDTH:0]     words_written_q, words_written_d;
    logic                       frame_done_q, frame_done_d;
    logic                       overflow_q, overflow_d;

    logic                       start, push, flush, emit;
    pixel_width_t               width_sel;
    logic [WORD_BITS-1:0]       packed_word;
    logic [ADDRESS_WIDTH:0]     count_base;

    // The start cycle packs with the freshly decoded width, not the stale latch.
    assign start     = (state_q == IDLE) && frame_valid_in;
    assign width_sel = start ? decode_width(pixel_width_in) : width_q;
    assign push      = write_enable_in && frame_valid_in && (start || (state_q == ACTIVE));
    assign flush     = (state_q == FLUSH);

    pixel_packer u_packer (
        .clock_spi_in (clock_spi_in),
        .reset_sync_n (reset_sync_n),
        .clear_in     (start),
        .push_in      (push),
        .flush_in     (flush),
        .width_in     (width_sel),
        .rgb10_in     (rgb10_in),
        .rgb8_in      (rgb8_in),
        .gray4_in     (gray4_in),
        .emit_out     (emit),
        .word_out     (packed_word)
    );

    always_comb begin
        state_d = state_q;
        width_d = width_q;
        case (state_q)
            IDLE: begin
                if (frame_valid_in) begin
                    state_d = ACTIVE;
                    width_d = width_sel;
                end
            end
            ACTIVE:  if (!frame_valid_in) state_d = FLUSH;
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_base      = start ? '0 : words_written_q;
        address_d       = start ? '0 : address_q;
        overflow_d      = start ? 1'b0 : overflow_q;
        words_written_d = count_base;
        write_enable_d  = 1'b0;
        pixel_data_d    = pixel_data_q;
        frame_done_d    = (state_q == DONE);

        // Once the last address has been written, further words are dropped.
        if (emit) begin
            if (count_base[ADDRESS_WIDTH]) begin
                overflow_d = 1'b1;
            end else begin
                write_enable_d  = 1'b1;
                pixel_data_d    = packed_word;
                address_d       = count_base[ADDRESS_WIDTH-1:0];
                words_written_d = sat_inc(count_base);
            end
        end
    end

    always_ff @(posedge clock_spi_in or negedge reset_sync_n) begin
        if (!reset_sync_n) begin
            state_q         <= IDLE;
            width_q         <= PW_8;
            write_enable_q  <= 1'b0;
            pixel_data_q    <= '0;
            address_q       <= '0;
            words_written_q <= '0;
            frame_done_q    <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            width_q         <= width_d;
            write_enable_q  <= write_enable_d;
            pixel_data_q    <= pixel_data_d;
            address_q       <= address_d;
            words_written_q <= words_written_d;
            frame_done_q    <= frame_done_d;
            overflow_q      <= overflow_d;
        end
    end

    assign write_enable_out  = write_enable_q;
    assign pixel_data_out    = pixel_data_q;
    assign address_out       = address_q;
    assign words_written_out = words_written_q;
    assign frame_done_out    = frame_done_q;
    assign overflow_out      = overflow_q;

endmodule
